bcd_down_timer: RTL and testbench
=================================

BCD_DOWN_TIMER -- requirements
Module: bcd_down_timer

Interface
REQ-001 Parameter: DIGITS, default 4, number of BCD digits (1..8).
REQ-002 Port: clk  input  1  rising-edge clock; sole clock of the block.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: load  input  1  one-cycle request to load load_value.
REQ-005 Port: load_value  input  4*DIGITS  packed BCD preset; digit 0 in bits [3:0].
REQ-006 Port: start  input  1  run/resume request.
REQ-007 Port: stop  input  1  pause request.
REQ-008 Port: tick  input  1  count enable; one decrement per tick cycle in RUN.
REQ-009 Port: Q  output  4*DIGITS  current packed BCD count, registered.
REQ-010 Port: busy  output  1  high while in RUN.
REQ-011 Port: done  output  1  one-cycle pulse when the count reaches its terminal value.
REQ-012 Port: expired  output  1  level, high while in DONE.
REQ-013 Port: load_err  output  1  one-cycle pulse when a load is rejected.

Function
REQ-014 The FSM SHALL have states IDLE, RUN, PAUSE and DONE, with all outputs driven from registers.
REQ-015 Per-cycle input priority SHALL be: reset > load > stop > start > tick.
REQ-016 A load with every digit <= 9 SHALL, in any state, set Q = load_value and the reload register = load_value, and enter IDLE at the next edge.
REQ-017 A load with any digit > 9 SHALL leave Q, the reload register and the state unchanged, and SHALL pulse load_err for exactly one cycle.
REQ-018 start in IDLE or PAUSE with Q != 0 SHALL enter RUN; start with Q == 0 SHALL be ignored, and start in RUN or DONE SHALL be ignored.
REQ-019 stop in RUN SHALL enter PAUSE; stop in any other state SHALL be ignored; if stop and start are both high, stop wins.
REQ-020 In RUN with tick high, Q SHALL decrement by one in BCD: digit 0 decrements; a digit at 0 becomes 9 and borrows from the next digit.
REQ-021 tick SHALL have no effect outside RUN, or when load or stop is high in the same cycle.
REQ-022 A tick in RUN with Q == 1 SHALL produce the terminal behaviour of REQ-023 (or REQ-030 when the macro is defined).
REQ-023 Without the macro, the terminal behaviour SHALL be: Q = 0, done high for exactly one cycle (the first cycle Q reads 0), entry to DONE, expired = 1, busy = 0.
REQ-024 DONE SHALL hold Q = 0 and SHALL be left only by load or reset.
REQ-025 Q SHALL never hold a non-BCD digit, and the count SHALL never wrap below zero.
REQ-026 Latency: each output SHALL reflect a qualifying input one clock edge after it is sampled.

Reset
REQ-027 While reset is high at a clk edge, the block SHALL set Q = 0, reload register = 0, state = IDLE, and busy, done, expired and load_err = 0.
REQ-028 Reset asserted mid-operation SHALL abort any count with no done pulse, and all other inputs SHALL be ignored in that cycle.

Configuration
REQ-029 Macro BCD_DOWN_TIMER_AUTORELOAD_EN SHALL select the periodic (auto-reload) mode.
REQ-030 With the macro defined, a tick in RUN with Q == 1 SHALL set Q = reload register, pulse done for one cycle and stay in RUN; DONE and expired = 1 SHALL never occur, and the period SHALL be the reload value in ticks.
REQ-031 With the macro undefined, the one-shot behaviour of REQ-023 and REQ-024 SHALL apply and no reload path SHALL be synthesized into the count update.

Verification (DIGITS = 4)
REQ-032 Borrow: load 16'h0100, start, tick -> Q = 16'h0099; tick -> 16'h0098; busy = 1 throughout.
REQ-033 Terminal: load 16'h0003, start, 3 ticks -> Q = 0002, 0001, 0000; done pulses one cycle with Q = 0000; expired = 1, busy = 0; further ticks and start leave Q = 0000.
REQ-034 Invalid load: load 16'h00A5 while Q = 16'h0012 -> load_err = 1 for one cycle; Q stays 16'h0012; state unchanged.
REQ-035 Pause: in RUN at 16'h0050, stop and start high together -> PAUSE; 5 ticks leave Q = 16'h0050; start -> RUN; tick -> 16'h0049.
REQ-036 Reset: reset high in RUN at 16'h0042 with tick high -> next edge Q = 0, IDLE, no done pulse, all flags 0.
REQ-037 Macro defined: load 16'h0002, start, 4 ticks -> Q = 0001, 0002 (done pulse), 0001, 0002 (done pulse); expired stays 0.

Source files
------------

// File: rtl/bcd_down_timer.sv
// Packed-BCD down counter with IDLE/RUN/PAUSE/DONE control; BCD_DOWN_TIMER_AUTORELOAD_EN selects periodic auto-reload mode.
// Latency: every output is registered and reflects sampled inputs one clk edge later.
// Backpressure: none; tick is a count enable, and invalid loads are dropped with a load_err pulse.
module bcd_down_timer #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   Q,
    output logic                  busy,
    output logic                  done,
    output logic                  expired,
    output logic                  load_err
);

    localparam int W = 4 * DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [W-1:0]   r_q;
    logic [W-1:0]   w_q_nxt;
    logic           r_busy;
    logic           r_done;
    logic           w_done_nxt;
    logic           r_expired;
    logic           r_load_err;
    logic           w_load_err_nxt;
    logic           w_load_ok;
    logic           w_at_one;
    logic [W-1:0]   w_q_dec;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
    logic [W-1:0]   r_reload;
    logic [W-1:0]   w_reload_nxt;
`endif

    function automatic logic bcd_valid(input logic [W-1:0] v);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (v[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

    // Ripple borrow: zero digits become 9 until the first non-zero digit absorbs it.
    function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] v);
        logic [W-1:0] r;
        logic         borrow;
        logic [3:0]   d;
        r      = v;
        borrow = (v != '0);
        for (int i = 0; i < DIGITS; i++) begin
            d = v[4*i +: 4];
            if (borrow) begin
                if (d == 4'd0) begin
                    d = 4'd9;
                end else begin
                    d      = d - 4'd1;
                    borrow = 1'b0;
                end
            end
            r[4*i +: 4] = d;
        end
        return r;
    endfunction

    assign w_load_ok = bcd_valid(load_value);
    assign w_at_one  = (r_q == W'(1));
    assign w_q_dec   = bcd_dec(r_q);

    always_comb begin
        w_state_nxt    = r_state;
        w_q_nxt        = r_q;
        w_done_nxt     = 1'b0;
        w_load_err_nxt = 1'b0;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
        w_reload_nxt   = r_reload;
`endif
        if (load) begin
            if (w_load_ok) begin
                w_q_nxt     = load_value;
                w_state_nxt = ST_IDLE;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
                w_reload_nxt = load_value;
`endif
            end else begin
                w_load_err_nxt = 1'b1;
            end
        end else if (stop) begin
            if (r_state == ST_RUN) begin
                w_state_nxt = ST_PAUSE;
            end
        end else if (start && (r_state == ST_IDLE || r_state == ST_PAUSE) && r_q != '0) begin
            w_state_nxt = ST_RUN;
        end else if (tick && r_state == ST_RUN) begin
            if (w_at_one) begin
                w_done_nxt = 1'b1;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
                w_q_nxt     = r_reload;
`else
                w_q_nxt     = '0;
                w_state_nxt = ST_DONE;
`endif
            end else begin
                w_q_nxt = w_q_dec;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_q        <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_expired  <= 1'b0;
            r_load_err <= 1'b0;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
            r_reload   <= '0;
`endif
        end else begin
            r_state    <= w_state_nxt;
            r_q        <= w_q_nxt;
            r_busy     <= (w_state_nxt == ST_RUN);
            r_done     <= w_done_nxt;
            r_expired  <= (w_state_nxt == ST_DONE);
            r_load_err <= w_load_err_nxt;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
            r_reload   <= w_reload_nxt;
`endif
        end
    end

    assign Q        = r_q;
    assign busy     = r_busy;
    assign done     = r_done;
    assign expired  = r_expired;
    assign load_err = r_load_err;

endmodule

// File: tb/tb_bcd_down_timer.sv
// Bench for bcd_down_timer (DIGITS=4): directed scenarios plus randomized traffic against a decimal-integer model.
module tb_bcd_down_timer;

    localparam int D = 4;
    localparam int MI = 0, MR = 1, MP = 2, MD = 3;

    logic           clk;
    logic           reset;
    logic           load;
    logic [4*D-1:0] load_value;
    logic           start;
    logic           stop;
    logic           tick;
    logic [4*D-1:0] Q;
    logic           busy;
    logic           done;
    logic           expired;
    logic           load_err;

    int n_chk;
    int n_err;
    bit cmp_en;

    int m_val;
    int m_rel;
    int m_st;
    bit m_done;
    bit m_err;

    bcd_down_timer #(.DIGITS(D)) dut (
        .clk(clk), .reset(reset), .load(load), .load_value(load_value),
        .start(start), .stop(stop), .tick(tick), .Q(Q), .busy(busy),
        .done(done), .expired(expired), .load_err(load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int x;
        x = v;
        r = '0;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic bit bcd_ok(input logic [4*D-1:0] b);
        bit ok;
        ok = 1'b1;
        for (int i = 0; i < D; i++) if (b[4*i +: 4] > 4'd9) ok = 1'b0;
        return ok;
    endfunction

    function automatic int from_bcd(input logic [4*D-1:0] b);
        int v;
        int p;
        v = 0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            v = v + int'(b[4*i +: 4]) * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the count is a plain decimal integer; one step per sampled edge.
    task automatic model_update();
        m_done = 1'b0;
        m_err  = 1'b0;
        if (reset) begin
            m_val = 0; m_rel = 0; m_st = MI;
        end else if (load) begin
            if (bcd_ok(load_value)) begin
                m_val = from_bcd(load_value); m_rel = m_val; m_st = MI;
            end else begin
                m_err = 1'b1;
            end
        end else if (stop) begin
            if (m_st == MR) m_st = MP;
        end else if (start && (m_st == MI || m_st == MP) && m_val != 0) begin
            m_st = MR;
        end else if (tick && m_st == MR) begin
            if (m_val == 1) begin
                m_done = 1'b1;
`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
                m_val = m_rel;
`else
                m_val = 0;
                m_st  = MD;
`endif
            end else begin
                m_val = m_val - 1;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit r, input bit l, input logic [4*D-1:0] lv,
                         input bit sa, input bit so, input bit tk);
        reset = r; load = l; load_value = lv; start = sa; stop = so; tick = tk;
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("Q", 32'(Q), 32'(to_bcd(m_val)));
            chk("busy", 32'(busy), 32'(m_st == MR));
            chk("expired", 32'(expired), 32'(m_st == MD));
            chk("done", 32'(done), 32'(m_done));
            chk("load_err", 32'(load_err), 32'(m_err));
        end
    end

    initial begin
        n_chk = 0; n_err = 0; cmp_en = 1'b0;
        m_val = 0; m_rel = 0; m_st = MI; m_done = 0; m_err = 0;
        drive(1, 0, '0, 0, 0, 0);
        step(); step();
        drive(0, 0, '0, 0, 0, 0);
        cmp_en = 1'b1;
        chk("reset_Q", 32'(Q), 32'h0);
        chk("reset_flags", {28'd0, busy, done, expired, load_err}, 32'h0);

        drive(0, 0, '0, 1, 0, 0); step();
        chk("start_at_zero_ignored", 32'(busy), 32'h0);

        // Borrow across digits
        drive(0, 1, 16'h0100, 0, 0, 0); step();
        drive(0, 0, '0, 1, 0, 0); step();
        chk("borrow_busy", 32'(busy), 32'h1);
        drive(0, 0, '0, 0, 0, 1); step();
        chk("borrow_0099", 32'(Q), 32'h0099);
        step();
        chk("borrow_0098", 32'(Q), 32'h0098);
        chk("borrow_busy2", 32'(busy), 32'h1);

        // Rejected load
        drive(0, 1, 16'h0012, 0, 0, 0); step();
        drive(0, 1, 16'h00A5, 0, 0, 0); step();
        chk("badload_err", 32'(load_err), 32'h1);
        chk("badload_Q", 32'(Q), 32'h0012);
        drive(0, 0, '0, 0, 0, 0); step();
        chk("badload_err_clears", 32'(load_err), 32'h0);
        chk("badload_state", 32'(busy), 32'h0);

        // Pause with stop+start together
        drive(0, 1, 16'h0050, 0, 0, 0); step();
        drive(0, 0, '0, 1, 0, 0); step();
        drive(0, 0, '0, 1, 1, 1); step();
        chk("pause_busy", 32'(busy), 32'h0);
        drive(0, 0, '0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step();
        chk("pause_hold", 32'(Q), 32'h0050);
        drive(0, 0, '0, 1, 0, 0); step();
        chk("resume_busy", 32'(busy), 32'h1);
        drive(0, 0, '0, 0, 0, 1); step();
        chk("resume_0049", 32'(Q), 32'h0049);

        // Reset mid-run
        drive(0, 1, 16'h0042, 0, 0, 0); step();
        drive(0, 0, '0, 1, 0, 0); step();
        drive(1, 0, '0, 0, 0, 1); step();
        chk("midreset_Q", 32'(Q), 32'h0);
        chk("midreset_flags", {28'd0, busy, done, expired, load_err}, 32'h0);

`ifdef BCD_DOWN_TIMER_AUTORELOAD_EN
        drive(0, 1, 16'h0002, 0, 0, 0); step();
        drive(0, 0, '0, 1, 0, 0); step();
        drive(0, 0, '0, 0, 0, 1);
        step(); chk("ar_t1", 32'(Q), 32'h0001); chk("ar_t1_done", 32'(done), 32'h0);
        step(); chk("ar_t2", 32'(Q), 32'h0002); chk("ar_t2_done", 32'(done), 32'h1);
        step(); chk("ar_t3", 32'(Q), 32'h0001); chk("ar_t3_done", 32'(done), 32'h0);
        step(); chk("ar_t4", 32'(Q), 32'h0002); chk("ar_t4_done", 32'(done), 32'h1);
        chk("ar_expired", 32'(expired), 32'h0);
        chk("ar_busy", 32'(busy), 32'h1);
`else
        drive(0, 1, 16'h0003, 0, 0, 0); step();
        drive(0, 0, '0, 1, 0, 0); step();
        drive(0, 0, '0, 0, 0, 1);
        step(); chk("term_0002", 32'(Q), 32'h0002);
        step(); chk("term_0001", 32'(Q), 32'h0001); chk("term_nodone", 32'(done), 32'h0);
        step(); chk("term_0000", 32'(Q), 32'h0000);
        chk("term_done", 32'(done), 32'h1);
        chk("term_expired", 32'(expired), 32'h1);
        chk("term_busy", 32'(busy), 32'h0);
        step(); chk("term_done_once", 32'(done), 32'h0); chk("term_hold", 32'(Q), 32'h0);
        drive(0, 0, '0, 1, 0, 1); step();
        chk("term_start_ignored", 32'(expired), 32'h1);
        chk("term_start_Q", 32'(Q), 32'h0);
`endif

        // Randomized traffic, biased toward small counts so terminal events occur often
        for (int c = 0; c < 4000; c++) begin
            logic [4*D-1:0] lv;
            case ($urandom_range(0, 3))
                0: lv = 16'($urandom());
                1: lv = to_bcd(int'($urandom_range(0, 9999)));
                default: lv = to_bcd(int'($urandom_range(0, 25)));
            endcase
            drive($urandom_range(0, 199) == 0, $urandom_range(0, 24) == 0, lv,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 2) != 0);
            step();
        end

        drive(0, 0, '0, 0, 0, 0);
        step();
        @(posedge clk);
        cmp_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
